// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Holds the FSM state encoding, the key map and the default timing constants.
package keypad_pkg;

    localparam int SETTLE_DEF   = 1000;
    localparam int DEBOUNCE_DEF = 500000;

    typedef enum logic [1:0] {
        ST_SCAN       = 2'd0,
        ST_PRESS_DB   = 2'd1,
        ST_HELD       = 2'd2,
        ST_RELEASE_DB = 2'd3
    } state_t;

    // Nibble index is {col, row}; nibble 0 sits in bits [3:0].
    localparam logic [63:0] KEY_MAP = 64'hDCBA_E963_F852_0741;

    function automatic logic [3:0] key_code(input logic [1:0] c, input logic [1:0] r);
        int idx;
        idx = {28'd0, c, r};
        return KEY_MAP[idx*4 +: 4];
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
// Resets to all-ones so idle (active-low) lines read as released.
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks active-low columns, debounces press and
// release on the synchronized rows, and reports the hex code of the held key.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SETTLE_CYCLES   = SETTLE_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] dec,
    output logic       button_pressed,
    output logic       key_strobe
);

    localparam int CNT_MAX = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES : DEBOUNCE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // Returns {valid, index}; valid only when exactly one row is low.
    function automatic logic [2:0] single_low(input logic [3:0] v);
        case (v)
            4'b1110: return 3'b100;
            4'b1101: return 3'b101;
            4'b1011: return 3'b110;
            4'b0111: return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    state_t           r_state,   w_state_n;
    logic [CNT_W-1:0] r_cnt,     w_cnt_n;
    logic [1:0]       r_col_idx, w_col_n;
    logic [1:0]       r_row_idx, w_row_n;
    logic [3:0]       r_dec,     w_dec_n;
    logic             r_pressed, w_pressed_n;
    logic             r_strobe,  w_strobe_n;
    logic [3:0]       w_rsync;
    logic [3:0]       w_row_pat;
    logic [2:0]       w_hit;

    sync_2ff #(.WIDTH(4)) u_row_sync (
        .clk (clk),
        .rst (rst),
        .d   (row),
        .q   (w_rsync)
    );

    assign w_hit     = single_low(w_rsync);
    assign w_row_pat = ~(4'b0001 << r_row_idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_SCAN;
            r_cnt     <= '0;
            r_col_idx <= 2'd0;
            r_row_idx <= 2'd0;
            r_dec     <= 4'h0;
            r_pressed <= 1'b0;
            r_strobe  <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_cnt     <= w_cnt_n;
            r_col_idx <= w_col_n;
            r_row_idx <= w_row_n;
            r_dec     <= w_dec_n;
            r_pressed <= w_pressed_n;
            r_strobe  <= w_strobe_n;
        end
    end

    always_comb begin
        w_state_n   = r_state;
        w_cnt_n     = r_cnt;
        w_col_n     = r_col_idx;
        w_row_n     = r_row_idx;
        w_dec_n     = r_dec;
        w_pressed_n = r_pressed;
        w_strobe_n  = 1'b0;
        case (r_state)
            ST_SCAN: begin
                if (r_cnt >= SETTLE_LAST) begin
                    w_cnt_n = '0;
                    if (w_hit[2]) begin
                        w_row_n   = w_hit[1:0];
                        w_state_n = ST_PRESS_DB;
                    end else begin
                        w_col_n = r_col_idx + 2'd1;
                    end
                end else begin
                    w_cnt_n = sat_inc(r_cnt);
                end
            end
            ST_PRESS_DB: begin
                if (w_rsync == w_row_pat) begin
                    if (r_cnt >= DEB_LAST) begin
                        w_state_n   = ST_HELD;
                        w_cnt_n     = '0;
                        w_dec_n     = key_code(r_col_idx, r_row_idx);
                        w_pressed_n = 1'b1;
                        w_strobe_n  = 1'b1;
                    end else begin
                        w_cnt_n = sat_inc(r_cnt);
                    end
                end else begin
                    // Bounce or extra row: rescan the same column from scratch.
                    w_state_n = ST_SCAN;
                    w_cnt_n   = '0;
                end
            end
            ST_HELD: begin
                if (w_rsync[r_row_idx]) begin
                    w_state_n = ST_RELEASE_DB;
                    w_cnt_n   = '0;
                end
            end
            ST_RELEASE_DB: begin
                if (w_rsync[r_row_idx]) begin
                    if (r_cnt >= DEB_LAST) begin
                        w_state_n   = ST_SCAN;
                        w_cnt_n     = '0;
                        w_col_n     = r_col_idx + 2'd1;
                        w_pressed_n = 1'b0;
                    end else begin
                        w_cnt_n = sat_inc(r_cnt);
                    end
                end else begin
                    w_state_n = ST_HELD;
                    w_cnt_n   = '0;
                end
            end
            default: begin
                w_state_n = ST_SCAN;
                w_cnt_n   = '0;
            end
        endcase
    end

    assign col            = ~(4'b0001 << r_col_idx);
    assign dec            = r_dec;
    assign button_pressed = r_pressed;
    assign key_strobe     = r_strobe;

endmodule
